execute_load_store_return: RTL
==============================

// Module: execute_load_store_return
// PURPOSE
//  Memory-side counterpart of the execute LDST request path: accepts LDST requests, drives the data-memory port,
//  tracks outstanding requests in an in-order FIFO, and aligns/zero-extends returned load data for writeback.
//  Sits between the execute stage and the data memory/cache interface; responses return strictly in request order.
// PARAMETERS
//  P_DEPTH    4   max outstanding requests (power of two, 2..16)
//  P_DEPTH_N  2   log2(P_DEPTH)
// PORTS
//  iCLOCK          in   1   clock
//  iRESET_SYNC     in   1   synchronous reset, active high
//  iREQ_VALID      in   1   LDST request valid
//  oREQ_BUSY       out  1   request not accepted this cycle
//  iREQ_RW         in   1   0:load 1:store
//  iREQ_ADDR       in   32  byte address
//  iREQ_DATA       in   32  store data, already lane-shifted
//  iREQ_ORDER      in   2   0:byte 1:half 2:word
//  iREQ_SHIFT      in   2   load byte-lane shift
//  iREQ_MASK       in   4   byte-lane mask; 4'b0000 = misaligned/invalid
//  oMEM_REQ        out  1   memory request strobe
//  iMEM_BUSY       in   1   memory cannot accept
//  oMEM_RW         out  1   0:read 1:write
//  oMEM_ADDR       out  32  word address {iREQ_ADDR[31:2],2'b00}
//  oMEM_DATA       out  32  write data
//  oMEM_BE         out  4   byte enables
//  iMEM_VALID      in   1   one response per request, in order, no backpressure
//  iMEM_DATA       in   32  read data (ignored for stores)
//  oWB_VALID       out  1   aligned load result valid (1 cycle pulse)
//  oWB_DATA        out  32  aligned, zero-extended load data
//  oWB_MISALIGN    out  1   with oWB_VALID: load had mask 4'b0000
//  oIDLE           out  1   FIFO empty and no writeback pending
//  oPROTOCOL_ERR   out  1   sticky: iMEM_VALID seen with FIFO empty
// BEHAVIOUR
//  - Reset (iRESET_SYNC=1 at posedge): FIFO pointers/count=0, oWB_VALID=0, oWB_DATA=0, oWB_MISALIGN=0,
//    oPROTOCOL_ERR=0. Outstanding requests are discarded; any iMEM_VALID in the reset cycle is ignored.
//  - Request path (combinational): full = (count==P_DEPTH); oREQ_BUSY = iMEM_BUSY | full | iRESET_SYNC;
//    oMEM_REQ = iREQ_VALID & ~full & ~iRESET_SYNC. Accept = iREQ_VALID & ~oREQ_BUSY.
//  - oMEM_BE = iREQ_RW ? iREQ_MASK : 4'hF; oMEM_DATA = iREQ_DATA; oMEM_RW = iREQ_RW.
//  - Store with mask 4'b0000: still issued with BE=0 and tracked; memory must respond.
//  - On accept, push {rw, order, shift, mask} to FIFO. On iMEM_VALID with count!=0, pop head.
//    Simultaneous push+pop: count unchanged. Push cannot occur when full (busy), even if a pop happens that cycle.
//  - Pointers wrap modulo P_DEPTH; count is P_DEPTH_N+1 bits.
//  - iMEM_VALID with count==0: set oPROTOCOL_ERR, no pop, no writeback.
//  - Writeback (registered, latency 1 after iMEM_VALID): if popped entry is a load, next cycle oWB_VALID=1,
//    else oWB_VALID=0. Stores retire silently.
//    order 0: oWB_DATA = {24'h0, byte[shift]}; order 1: {16'h0, iMEM_DATA[16*shift[1]+:16]};
//    order 2: iMEM_DATA. mask==0: oWB_DATA=0, oWB_MISALIGN=1. order 3: treated as mask==0.
//  - oWB_DATA holds its last value when oWB_VALID=0.
//  - oIDLE = (count==0) & ~oWB_VALID.
// TESTING
//  - Reset, then LD32 at 0x100 (mask F); iMEM_DATA=0xDEADBEEF next cycle -> oMEM_ADDR=0x100, BE=F; oWB_DATA=0xDEADBEEF one cycle later.
//  - LD8 at addr 0x203 (shift 3, mask 1000), iMEM_DATA=0x11223344 -> oWB_DATA=0x00000011, MISALIGN=0.
//  - LD16 at addr 0x302 (shift 2, mask 1100), iMEM_DATA=0xAABBCCDD -> oWB_DATA=0x0000AABB; LD16 mask 0 -> oWB_DATA=0, MISALIGN=1.
//  - Issue 4 loads, no responses -> 5th request sees oREQ_BUSY=1; respond in cycle of 5th request -> still rejected,
//    accepted next cycle; four results return in issue order.
//  - ST8 (BE=0010) between two loads, responses back-to-back -> exactly two oWB_VALID pulses, none for the store.
//  - iMEM_VALID with empty FIFO -> oPROTOCOL_ERR=1 sticky, no oWB_VALID; reset with 2 outstanding -> oIDLE=1 next cycle.

Source files
------------

// File: rtl/execute_load_store_return.sv
// execute_load_store_return
//   Memory-side half of the execute LDST path. Requests from execute go
//   straight to the data-memory port. Each accepted request is recorded in an
//   in-order FIFO. Responses pop the FIFO head. Load data is lane-aligned and
//   zero-extended, then registered for writeback.
// Ports
//   iCLOCK, iRESET_SYNC         clock, synchronous active-high reset
//   iREQ_*  / oREQ_BUSY         request from execute (rw, addr, data, order, shift, mask)
//   oMEM_*  / iMEM_BUSY         request strobe to data memory (word address, BE)
//   iMEM_VALID, iMEM_DATA       in-order responses, one per request
//   oWB_VALID/DATA/MISALIGN     registered load result (1-cycle pulse)
//   oIDLE                       nothing outstanding, no writeback pending
//   oPROTOCOL_ERR               sticky: response arrived with nothing outstanding
module execute_load_store_return #(
  parameter int P_DEPTH   = 4,
  parameter int P_DEPTH_N = 2
)(
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iREQ_VALID,
  output logic        oREQ_BUSY,
  input  logic        iREQ_RW,
  input  logic [31:0] iREQ_ADDR,
  input  logic [31:0] iREQ_DATA,
  input  logic [1:0]  iREQ_ORDER,
  input  logic [1:0]  iREQ_SHIFT,
  input  logic [3:0]  iREQ_MASK,
  output logic        oMEM_REQ,
  input  logic        iMEM_BUSY,
  output logic        oMEM_RW,
  output logic [31:0] oMEM_ADDR,
  output logic [31:0] oMEM_DATA,
  output logic [3:0]  oMEM_BE,
  input  logic        iMEM_VALID,
  input  logic [31:0] iMEM_DATA,
  output logic        oWB_VALID,
  output logic [31:0] oWB_DATA,
  output logic        oWB_MISALIGN,
  output logic        oIDLE,
  output logic        oPROTOCOL_ERR
);

  typedef struct packed {
    logic       rw;
    logic [1:0] order;
    logic [1:0] shift;
    logic [3:0] mask;
  } ldst_ent_t;

  localparam logic [P_DEPTH_N:0] L_FULL = (P_DEPTH_N+1)'(P_DEPTH);

  ldst_ent_t              fifo [P_DEPTH];
  ldst_ent_t              head;
  logic [P_DEPTH_N-1:0]   wr_ptr, rd_ptr;
  logic [P_DEPTH_N:0]     count;
  logic                   full, accept, pop;
  logic [31:0]            wb_data_nxt;
  logic                   wb_mis_nxt;

  // byte offset is implied by the BE/shift fields; only the word address goes out
  logic unused_addr_lo;
  assign unused_addr_lo = ^iREQ_ADDR[1:0];

  // request path
  assign full      = (count == L_FULL);
  assign oREQ_BUSY = iMEM_BUSY | full | iRESET_SYNC;
  assign oMEM_REQ  = iREQ_VALID & ~full & ~iRESET_SYNC;
  assign accept    = iREQ_VALID & ~oREQ_BUSY;
  assign oMEM_RW   = iREQ_RW;
  assign oMEM_ADDR = {iREQ_ADDR[31:2], 2'b00};
  assign oMEM_DATA = iREQ_DATA;
  assign oMEM_BE   = iREQ_RW ? iREQ_MASK : 4'hF;

  // a response with nothing outstanding is flagged, never popped
  assign pop  = iMEM_VALID & (count != '0);
  assign head = fifo[rd_ptr];

  // lane alignment of the returning word for the head entry
  always_comb begin
    wb_data_nxt = '0;
    wb_mis_nxt  = 1'b0;
    if (head.mask == 4'b0000 || head.order == 2'd3) begin
      wb_mis_nxt = 1'b1;
    end else begin
      case (head.order)
        2'd0:    wb_data_nxt = {24'h0, iMEM_DATA[{head.shift, 3'b000} +: 8]};
        2'd1:    wb_data_nxt = {16'h0, iMEM_DATA[{head.shift[1], 4'b0000} +: 16]};
        default: wb_data_nxt = iMEM_DATA;
      endcase
    end
  end

  // entry storage needs no reset; pointers/count qualify it
  always_ff @(posedge iCLOCK) begin
    if (accept)
      fifo[wr_ptr] <= '{rw: iREQ_RW, order: iREQ_ORDER, shift: iREQ_SHIFT, mask: iREQ_MASK};
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      oWB_VALID     <= 1'b0;
      oWB_DATA      <= '0;
      oWB_MISALIGN  <= 1'b0;
      oPROTOCOL_ERR <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (iMEM_VALID && count == '0) oPROTOCOL_ERR <= 1'b1;
      // stores retire silently; data holds when no load result is written
      oWB_VALID <= pop & ~head.rw;
      if (pop && !head.rw) begin
        oWB_DATA     <= wb_data_nxt;
        oWB_MISALIGN <= wb_mis_nxt;
      end
    end
  end

  assign oIDLE = (count == '0) & ~oWB_VALID;

endmodule
